// File: rtl/alu_exec_if.sv
// ---------------------------------------------------------------------------
// alu_exec_if
// Handshake and operand bus of the execute-stage ALU.
//   master : issue side (decode/issue drives operands and in_valid, the
//            writeback side drives out_ready and reads result/flags)
//   slave  : the alu_exec_unit itself
// Signals:
//   in_valid/in_ready      accept handshake
//   a_reg/a_wb/a_alu       operand A sources (regfile, wb forward, alu forward)
//   b_reg/b_wb/b_alu       operand B sources
//   imm                    sign-extended immediate
//   sel_a/sel_b            00 reg, 01 wb, 10 alu, 11 reg
//   alu_src                1: B operand = imm
//   alu_op                 4-bit opcode
//   out_valid/out_ready    result handshake
//   result                 registered result
//   negative/zero/carry/overflow/illegal  registered flags
//   busy                   multi-cycle op in progress
// ---------------------------------------------------------------------------
interface alu_exec_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] a_wb;
  logic [WIDTH-1:0] a_alu;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] b_wb;
  logic [WIDTH-1:0] b_alu;
  logic [WIDTH-1:0] imm;
  logic [1:0]       sel_a;
  logic [1:0]       sel_b;
  logic             alu_src;
  logic [3:0]       alu_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             negative;
  logic             zero;
  logic             carry;
  logic             overflow;
  logic             illegal;
  logic             busy;

  modport master (
    output in_valid, a_reg, a_wb, a_alu, b_reg, b_wb, b_alu, imm,
           sel_a, sel_b, alu_src, alu_op, out_ready,
    input  in_ready, out_valid, result, negative, zero, carry, overflow,
           illegal, busy
  );

  modport slave (
    input  in_valid, a_reg, a_wb, a_alu, b_reg, b_wb, b_alu, imm,
           sel_a, sel_b, alu_src, alu_op, out_ready,
    output in_ready, out_valid, result, negative, zero, carry, overflow,
           illegal, busy
  );
endinterface

// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
// Execute-stage ALU with operand forwarding, a registered result behind a
// valid/ready handshake, and an iterative shift-add multiplier. The
// restoring divider (DIVU/REMU) is only built when the macro DIVIDER_EN is
// defined; without it those opcodes are reported as illegal.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   alu_exec_if slave modport (operands, opcode, handshakes, result,
//         flags, illegal, busy)
// Parameters:
//   WIDTH datapath width (power of 2, >= 8)
//   SHW   shift-amount width, taken from B[SHW-1:0]
// ---------------------------------------------------------------------------
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic      clk,
  input  logic      rst,
  alu_exec_if.slave bus
);
  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_SLL   = 4'b0100;
  localparam logic [3:0] OP_SRL   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SRA   = 4'b0111;
  localparam logic [3:0] OP_SLT   = 4'b1000;
  localparam logic [3:0] OP_SLTU  = 4'b1001;
  localparam logic [3:0] OP_MUL   = 4'b1010;
  localparam logic [3:0] OP_MULHU = 4'b1011;
  localparam logic [3:0] OP_DIVU  = 4'b1100;
  localparam logic [3:0] OP_REMU  = 4'b1101;

`ifdef DIVIDER_EN
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_MUL} state_t;
`endif

  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
    return (sa != sb) && (sr != sa);
  endfunction

  // Operand forwarding and immediate select
  logic [WIDTH-1:0] op_a, op_b_fwd, op_b;

  always_comb begin
    case (bus.sel_a)
      2'b01:   op_a = bus.a_wb;
      2'b10:   op_a = bus.a_alu;
      default: op_a = bus.a_reg;
    endcase
    case (bus.sel_b)
      2'b01:   op_b_fwd = bus.b_wb;
      2'b10:   op_b_fwd = bus.b_alu;
      default: op_b_fwd = bus.b_reg;
    endcase
    op_b = bus.alu_src ? bus.imm : op_b_fwd;
  end

  // Single-cycle datapath
  logic signed [WIDTH-1:0] a_s, b_s;
  logic [WIDTH:0]          add_w, sub_w;
  logic [SHW-1:0]          shamt;
  logic [WIDTH-1:0]        sc_res;
  logic                    sc_c, sc_v, sc_ill;

  assign a_s   = op_a;
  assign b_s   = op_b;
  assign shamt = op_b[SHW-1:0];
  assign add_w = {1'b0, op_a} + {1'b0, op_b};
  // A + ~B + 1: the carry-out is the no-borrow flag
  assign sub_w = {1'b0, op_a} + {1'b0, ~op_b} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    sc_ill = 1'b0;
    case (bus.alu_op)
      OP_AND:  sc_res = op_a & op_b;
      OP_OR:   sc_res = op_a | op_b;
      OP_XOR:  sc_res = op_a ^ op_b;
      OP_ADD: begin
        sc_res = add_w[WIDTH-1:0];
        sc_c   = add_w[WIDTH];
        sc_v   = add_ovf(op_a[WIDTH-1], op_b[WIDTH-1], add_w[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = sub_w[WIDTH-1:0];
        sc_c   = sub_w[WIDTH];
        sc_v   = sub_ovf(op_a[WIDTH-1], op_b[WIDTH-1], sub_w[WIDTH-1]);
      end
      OP_SLL:  sc_res = op_a << shamt;
      OP_SRL:  sc_res = op_a >> shamt;
      OP_SRA:  sc_res = a_s >>> shamt;
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
      default: sc_ill = 1'b1;
    endcase
  end

  // Multi-cycle decode and control
  logic is_mul, is_div, is_multi;
  assign is_mul = (bus.alu_op == OP_MUL) || (bus.alu_op == OP_MULHU);
`ifdef DIVIDER_EN
  assign is_div = (bus.alu_op == OP_DIVU) || (bus.alu_op == OP_REMU);
`else
  assign is_div = 1'b0;
`endif
  assign is_multi = is_mul || is_div;

  state_t           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_hi_q, acc_lo_q, opnd_q;
  logic             hi_sel_q;
  logic             out_valid_q, out_valid_d;
  logic             in_ready, busy, last, out_free, accept, start;
  logic             step_en, multi_done;

  assign out_free = !out_valid_q || bus.out_ready;
  // cnt_q counts completed iterations; the first one runs on the accept edge
  assign last     = (cnt_q == SHW'(WIDTH - 1));
  assign accept   = bus.in_valid && in_ready;
  assign start    = accept && is_multi;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept && is_mul) state_d = S_MUL;
`ifdef DIVIDER_EN
        if (accept && is_div) state_d = S_DIV;
`endif
      end
      default: if (last && out_free) state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q != S_IDLE);
    in_ready   = (state_q == S_IDLE) && out_free;
    step_en    = busy && !last;
    // The final iteration stalls here until the output register is free
    multi_done = busy && last && out_free;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (start)           cnt_d = SHW'(1);
    else if (multi_done) cnt_d = '0;
    else if (step_en)    cnt_d = cnt_q + SHW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Iteration step. hi/lo form a 2*WIDTH shift register: product {hi,lo}
  // for multiply, {remainder,quotient} for divide. On the accept edge the
  // step runs on the freshly muxed operands instead of the registers.
  logic [WIDTH-1:0] src_hi, src_lo, src_opnd, nxt_hi, nxt_lo;
  logic [WIDTH:0]   mul_sum;

  always_comb begin
    src_hi   = start ? '0 : acc_hi_q;
    src_lo   = acc_lo_q;
    src_opnd = opnd_q;
    if (start) begin
      src_lo   = is_div ? op_a : op_b;
      src_opnd = is_div ? op_b : op_a;
    end
  end

  assign mul_sum = {1'b0, src_hi} + (src_lo[0] ? {1'b0, src_opnd} : {(WIDTH+1){1'b0}});

`ifdef DIVIDER_EN
  logic           div_q, div_mode, div_ge;
  logic [WIDTH:0] div_sh, div_diff;

  assign div_mode = start ? is_div : div_q;
  assign div_sh   = {src_hi, src_lo[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, src_opnd};
  assign div_ge   = !div_diff[WIDTH];

  // A zero divisor always "fits", giving all-ones quotient and rem = dividend
  always_comb begin
    if (div_mode) begin
      nxt_hi = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
      nxt_lo = {src_lo[WIDTH-2:0], div_ge};
    end else begin
      nxt_hi = mul_sum[WIDTH:1];
      nxt_lo = {mul_sum[0], src_lo[WIDTH-1:1]};
    end
  end
`else
  assign nxt_hi = mul_sum[WIDTH:1];
  assign nxt_lo = {mul_sum[0], src_lo[WIDTH-1:1]};
`endif

  always_ff @(posedge clk) begin
    if (start || step_en) begin
      acc_hi_q <= nxt_hi;
      acc_lo_q <= nxt_lo;
    end
    if (start) begin
      opnd_q   <= src_opnd;
      hi_sel_q <= (bus.alu_op == OP_MULHU) || (bus.alu_op == OP_REMU);
`ifdef DIVIDER_EN
      div_q    <= is_div;
`endif
    end
  end

  // Output register
  logic [WIDTH-1:0] result_q, result_d, load_val;
  logic             neg_q, neg_d, zero_q, zero_d, carry_q, carry_d;
  logic             ovf_q, ovf_d, ill_q, ill_d;

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    neg_d       = neg_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    ill_d       = ill_q;
    load_val    = hi_sel_q ? nxt_hi : nxt_lo;
    if (multi_done) begin
      out_valid_d = 1'b1;
      carry_d     = 1'b0;
      ovf_d       = 1'b0;
      ill_d       = 1'b0;
    end else if (accept && !is_multi) begin
      out_valid_d = 1'b1;
      load_val    = sc_res;
      carry_d     = sc_c;
      ovf_d       = sc_v;
      ill_d       = sc_ill;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    if (multi_done || (accept && !is_multi)) begin
      result_d = load_val;
      neg_d    = load_val[WIDTH-1];
      zero_d   = (load_val == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      neg_q       <= 1'b0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      ill_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      neg_q       <= neg_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      ill_q       <= ill_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.busy      = busy;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.negative  = neg_q;
  assign bus.zero      = zero_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = ovf_q;
  assign bus.illegal   = ill_q;
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Parametrised execute-stage ALU, successor to the combinational forwarding ALU top. It keeps the same operand-forwarding muxes, immediate select, opcode set and NZCV-style flags. It adds a registered output with a valid/ready handshake and iterative multi-cycle multiply (and optionally divide). It sits between the decode/issue stage and writeback.

Parameters:
WIDTH, 32, datapath width in bits (power of 2, >=8)
SHW, $clog2(WIDTH), shift-amount width taken from B[SHW-1:0]

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  operation offered
in_ready  output  1  unit can accept this cycle
a_reg, a_wb, a_alu  input  WIDTH  operand A sources: register file, writeback forward, ALU forward
b_reg, b_wb, b_alu  input  WIDTH  operand B sources, same meaning
imm  input  WIDTH  sign-extended immediate
sel_a, sel_b  input  2  00 reg, 01 wb, 10 alu, 11 reg
alu_src  input  1  1: B operand = imm (applied after sel_b mux)
alu_op  input  4  opcode
out_valid  output  1  result register holds a result
out_ready  input  1  consumer takes result
result  output  WIDTH  registered result
negative, zero, carry, overflow  output  1  registered flags
illegal  output  1  registered: opcode unsupported
busy  output  1  multi-cycle op in progress

Behaviour:
- Reset: out_valid=0, result=0, all flags=0, illegal=0, busy=0, FSM=IDLE, iteration counter=0. Reset mid-operation aborts the op with no output.
- Accept: in_valid && in_ready. in_ready = (state==IDLE) && (!out_valid || out_ready).
- Opcodes: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SUB, 0111 SRA, 1000 SLT (signed, result 0/1), 1001 SLTU, 1010 MUL (low WIDTH bits), 1011 MULHU (high WIDTH bits, unsigned), 1100 DIVU, 1101 REMU, 1110/1111 reserved.
- Single-cycle ops (0000-1001): result and flags are registered at acceptance; out_valid=1 the next cycle (latency 1).
- Reserved ops: latency 1, result=0, illegal=1, zero=1, other flags 0.
- Flags: zero = (result==0); negative = result[WIDTH-1]. ADD: carry = carry-out, overflow = signed overflow. SUB: carry = no-borrow (A>=B unsigned), overflow = signed overflow. All other ops: carry=0, overflow=0.
- FSM states: IDLE, MUL, DIV. Accepting op 1010/1011 goes to MUL; accepting 1100/1101 goes to DIV; busy=1 in MUL/DIV.
- MUL: shift-add, one bit per cycle, WIDTH iterations. The 2*WIDTH product is complete after the final iteration, and result is loaded on that cycle, so out_valid rises WIDTH cycles after acceptance. Loading requires the output register to be free (!out_valid || out_ready). Otherwise the FSM holds in the final iteration until it is free, then returns to IDLE.
- DIV: restoring, one quotient bit per cycle, WIDTH iterations, same completion/hold rule as MUL.
- Divide by zero: DIVU result = all ones; REMU result = dividend; no trap.
- Output register: out_valid clears on out_ready with no new load. Simultaneous consume and new load keeps out_valid=1 with the new data. result and flags are stable while out_valid && !out_ready.
- Operands are captured at acceptance; changes on input ports during MUL/DIV are ignored.

Optional Feature:
DIVIDER_EN. Defined: DIV state and divider datapath are present; 1100/1101 behave as above. Undefined: no divider logic is built; 1100/1101 are treated as reserved (latency 1, result=0, illegal=1).

Test Plan:
- WIDTH=32, sel=00, alu_src=0, a_reg=10, b_reg=5, ADD -> next cycle result=15, flags 0; SUB -> result=5, carry=1; SUB with a=5, b=10 -> result=0xFFFFFFFB, negative=1, carry=0.
- Forwarding: sel_a=10 with a_alu=0x80000000; sel_b=01 with b_wb=2; SRA -> 0xE0000000; SRL -> 0x20000000; alu_src=1 with imm=1 and ADD of 0x7FFFFFFF -> 0x80000000, overflow=1.
- MUL of 0x00010000 x 0x00010000 -> result=0, zero=1, out_valid exactly 32 cycles after accept, in_ready=0 meanwhile; MULHU of the same operands -> result=1.
- DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 9/0 -> 0xFFFFFFFF; REMU 9/0 -> 9; repeat with DIVIDER_EN undefined -> result=0, illegal=1 at latency 1.
- Backpressure: out_ready=0 after an ADD -> result held; a MUL completing meanwhile holds busy=1 until out_ready=1, then delivers. Back-to-back ADDs with out_ready=1 -> one result per cycle.
- Reset asserted for 1 cycle mid-MUL (cycle 10) -> next cycle out_valid=0, busy=0, in_ready=1; no stale result appears later.
